// File: rtl/seq_101_framer.sv
// -----------------------------------------------------------------------------
// seq_101_framer
//
// Serial transmitter for the "101"-delimited bit stream. A parallel word is
// taken over a valid/ready handshake and sent as: sync 1,0,1, then the payload
// MSB first with zero-stuffing, then GAP idle zeros. Stuffing guarantees that
// "101" only ever appears on the line at a sync.
//
// Parameters:
//   DATA_W  payload width in bits (>= 1)
//   GAP     idle zero cycles after each frame (>= 1)
//
// Ports:
//   clk         clock, rising edge
//   rst         asynchronous reset, active low
//   tx_valid    source has a word on tx_data
//   tx_data     payload word, sampled at the handshake edge
//   tx_ready    framer idle, a word transfers on the next edge if tx_valid=1
//   sout        registered serial line, idles at 0
//   busy        registered, high on every cycle sout carries sync/data/stuff/gap
//   frame_done  registered one-cycle pulse on the first gap cycle
//
// State table (state = what the NEXT edge drives onto sout):
//   state  | meaning
//   IDLE   | line idle; accept a word and drive the first sync bit
//   SYNC   | drive the remaining sync bits 0,1 (sync_cnt selects which)
//   DATA   | drive payload MSB first, or a stuff 0 when history is 1,0
//   GAP    | drive idle zeros; gap_cnt counts down to the last one
// -----------------------------------------------------------------------------
module seq_101_framer #(
  parameter int DATA_W = 8,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_valid,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              sout,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_DATA = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] shreg, shreg_nxt;
  logic [BIT_W-1:0]  bit_cnt, bit_cnt_nxt;
  logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
  logic              sync_cnt, sync_cnt_nxt;
  logic [1:0]        h, h_nxt;
  logic              sout_nxt;
  logic              busy_nxt;
  logic              done_nxt;

  // Handshake is only possible while the next edge is free to start a frame.
  assign tx_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sync_cnt   <= 1'b0;
      h          <= 2'b00;
      sout       <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      shreg      <= shreg_nxt;
      bit_cnt    <= bit_cnt_nxt;
      gap_cnt    <= gap_cnt_nxt;
      sync_cnt   <= sync_cnt_nxt;
      h          <= h_nxt;
      sout       <= sout_nxt;
      busy       <= busy_nxt;
      frame_done <= done_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    bit_cnt_nxt  = bit_cnt;
    gap_cnt_nxt  = gap_cnt;
    sync_cnt_nxt = sync_cnt;
    sout_nxt     = 1'b0;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_valid) begin
          shreg_nxt    = tx_data;
          bit_cnt_nxt  = BIT_LAST;
          sync_cnt_nxt = 1'b1;
          sout_nxt     = 1'b1;
          busy_nxt     = 1'b1;
          state_nxt    = S_SYNC;
        end
      end

      S_SYNC: begin
        busy_nxt = 1'b1;
        if (sync_cnt) begin
          sout_nxt     = 1'b0;
          sync_cnt_nxt = 1'b0;
        end else begin
          sout_nxt  = 1'b1;
          state_nxt = S_DATA;
        end
      end

      S_DATA: begin
        busy_nxt = 1'b1;
        // Line just carried 1,0: any 1 now would form "101", so insert a 0
        // and keep the pending payload bit for the next cycle.
        if (h == 2'b10) begin
          sout_nxt = 1'b0;
        end else begin
          sout_nxt  = shreg[DATA_W-1];
          shreg_nxt = shreg << 1;
          if (bit_cnt == '0) begin
            gap_cnt_nxt = GAP_LAST;
            state_nxt   = S_GAP;
          end else begin
            bit_cnt_nxt = bit_cnt - BIT_ONE;
          end
        end
      end

      S_GAP: begin
        busy_nxt = 1'b1;
        sout_nxt = 1'b0;
        done_nxt = (gap_cnt == GAP_LAST);
        // Leaving on the edge that drives the last zero lets a queued word
        // start its sync right after exactly GAP zeros.
        if (gap_cnt == '0) begin
          state_nxt = S_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt - GAP_ONE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    h_nxt = {h[0], sout_nxt};
  end

endmodule

// File: tb/tb_seq_101_framer.sv
module tb_seq_101_framer;
  localparam int DATA_W = 8;
  localparam int GAP    = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tx_valid = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic              tx_ready, sout, busy, frame_done;

  seq_101_framer #(.DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .sout(sout), .busy(busy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as the line must carry it: sync, stuffed payload, gap. Returned
  // right-aligned, first bit at position len-1.
  function automatic logic [63:0] frame_vec(input logic [DATA_W-1:0] w, output int len);
    logic [63:0] v;
    logic [1:0]  last2;
    v = '0; len = 0;
    v = {v[60:0], 3'b101}; len = 3;
    last2 = 2'b01;
    for (int i = DATA_W - 1; i >= 0; i--) begin
      if (last2 == 2'b10) begin
        v = {v[62:0], 1'b0}; len++; last2 = {last2[0], 1'b0};
      end
      v = {v[62:0], w[i]}; len++; last2 = {last2[0], w[i]};
    end
    for (int g = 0; g < GAP; g++) begin
      v = {v[62:0], 1'b0}; len++;
    end
    return v;
  endfunction

  typedef struct { logic b; logic done; logic sync; } ent_t;
  ent_t              q[$];
  logic [DATA_W-1:0] sent_q[$];
  int                acc_cnt = 0;
  logic exp_sout = 0, exp_busy = 0, exp_done = 0, exp_ready = 1, exp_sync = 0;
  logic chk_en = 0;

  // Model: each accepted word becomes a queue of line bits; the framer is
  // ready whenever no bits of the current frame remain to be sent.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete(); sent_q.delete();
      exp_sout = 0; exp_busy = 0; exp_done = 0; exp_ready = 1; exp_sync = 0;
    end else begin
      if (q.size() == 0 && tx_valid) begin
        logic [63:0] v; int len;
        v = frame_vec(tx_data, len);
        for (int i = 0; i < len; i++) begin
          ent_t e;
          e.b = v[len-1-i]; e.done = (i == len - GAP); e.sync = (i == 0);
          q.push_back(e);
        end
        sent_q.push_back(tx_data);
        acc_cnt++;
      end
      if (q.size() > 0) begin
        ent_t e;
        e = q.pop_front();
        exp_sout = e.b; exp_busy = 1; exp_done = e.done; exp_sync = e.sync;
      end else begin
        exp_sout = 0; exp_busy = 0; exp_done = 0; exp_sync = 0;
      end
      exp_ready = (q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (rst && chk_en) begin
      check("cyc_sout", sout, exp_sout);
      check("cyc_busy", busy, exp_busy);
      check("cyc_frame_done", frame_done, exp_done);
      check("cyc_tx_ready", tx_ready, exp_ready);
    end
  end

  // Line-side receiver: 101 detector plus destuffer recovering words.
  logic [2:0]        win = 0, sfl = 0;
  logic              collecting = 0;
  logic [1:0]        rl2 = 0;
  int                kept = 0, det_cnt = 0, rec_cnt = 0;
  logic [DATA_W-1:0] word = 0;

  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      win = 0; sfl = 0; collecting = 0; kept = 0; rl2 = 0; word = 0;
    end else if (chk_en) begin
      win = {win[1:0], sout};
      sfl = {sfl[1:0], exp_sync};
      if (collecting) begin
        if (!(rl2 == 2'b10 && sout == 1'b0)) begin
          word = (word << 1) | DATA_W'(sout);
          kept++;
          if (kept == DATA_W) begin
            collecting = 0;
            rec_cnt++;
            if (sent_q.size() == 0) check("rx_unexpected_word", 1, 0);
            else check("rx_word", word, sent_q.pop_front());
          end
        end
        rl2 = {rl2[0], sout};
      end
      if (win == 3'b101) begin
        det_cnt++;
        check("rx_101_at_sync", sfl[2], 1);
        collecting = 1; kept = 0; rl2 = 2'b01; word = 0;
      end
    end
  end

  task automatic send_capture(input logic [DATA_W-1:0] w, input int ncap,
                              output logic [31:0] cap, output logic [31:0] rdy,
                              output logic [31:0] dn);
    int prev, n;
    cap = 0; rdy = 0; dn = 0;
    @(posedge clk); #2;
    tx_valid = 1; tx_data = w;
    prev = acc_cnt; n = 0;
    do begin @(posedge clk); #2; n++; end while (acc_cnt == prev && n < 50);
    if (acc_cnt == prev) check("accept_timeout", 0, 1);
    tx_valid = 0;
    for (int i = 0; i < ncap; i++) begin
      @(negedge clk);
      cap = {cap[30:0], sout};
      rdy = {rdy[30:0], tx_ready};
      dn  = {dn[30:0], frame_done};
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] v;
    int          len;
    logic [31:0] cap, rdy, dn;
    int          prev, n, det0, rec0;

    // Model pins against hand-derived frames.
    v = frame_vec(8'hA5, len);
    check("pin_len_a5", len, 16);
    check("pin_bits_a5", v[31:0], 32'h0000B224);
    v = frame_vec(8'hFF, len);
    check("pin_len_ff", len, 13);
    check("pin_bits_ff", v[31:0], 32'h000017FC);
    v = frame_vec(8'h00, len);
    check("pin_len_00", len, 14);
    check("pin_bits_00", v[31:0], 32'h00002800);

    repeat (3) @(posedge clk);
    #1;
    check("rst_sout", sout, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_done", frame_done, 0);
    #1 rst = 1;
    chk_en = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_sout", sout, 0);
      check("idle_busy", busy, 0);
      check("idle_ready", tx_ready, 1);
      check("idle_done", frame_done, 0);
    end

    send_capture(8'hA5, 18, cap, rdy, dn);
    check("a5_frame", cap[17:2], 16'hB224);
    check("a5_idle_after", cap[1:0], 0);
    check("a5_done_pos", dn[17:0], 18'b00_0000_0000_0000_1000);
    check("a5_ready_c14", rdy[3], 0);
    check("a5_ready_c15", rdy[2], 1);

    send_capture(8'hFF, 13, cap, rdy, dn);
    check("ff_frame", cap[12:0], 13'h17FC);
    send_capture(8'h00, 14, cap, rdy, dn);
    check("00_frame", cap[13:0], 14'h2800);

    // Back-to-back with tx_valid held.
    repeat (3) @(posedge clk);
    #2;
    tx_valid = 1; tx_data = 8'hA5;
    prev = acc_cnt; n = 0;
    do begin @(posedge clk); #2; n++; end while (acc_cnt == prev && n < 50);
    if (acc_cnt == prev) check("b2b_accept_timeout", 0, 1);
    tx_data = 8'h5A;
    det0 = det_cnt;
    cap = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      cap = {cap[30:0], sout};
      if (i == 16) tx_valid = 0;
    end
    check("b2b_stream", cap, 32'hB224A4C8);
    check("b2b_accepts", acc_cnt - prev, 2);
    check("b2b_detects", det_cnt - det0, 2);

    // Reset in the middle of the data field.
    repeat (2) @(posedge clk);
    #2;
    tx_valid = 1; tx_data = 8'hA5;
    prev = acc_cnt; n = 0;
    do begin @(posedge clk); #2; n++; end while (acc_cnt == prev && n < 50);
    tx_valid = 0;
    repeat (5) @(negedge clk);
    #2 rst = 0;
    #1;
    check("abort_sout", sout, 0);
    check("abort_busy", busy, 0);
    check("abort_ready", tx_ready, 1);
    check("abort_done", frame_done, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1;
    send_capture(8'hFF, 13, cap, rdy, dn);
    check("post_abort_frame", cap[12:0], 13'h17FC);

    // Random words with random idle gaps, including back-to-back.
    repeat (4) @(posedge clk);
    rec0 = rec_cnt;
    #2;
    for (int k = 0; k < 1000; k++) begin
      int g;
      g = $urandom_range(0, 3);
      if (g != 0) begin
        tx_valid = 0;
        repeat (g) begin @(posedge clk); #2; end
      end
      tx_data = DATA_W'($urandom);
      tx_valid = 1;
      prev = acc_cnt; n = 0;
      do begin @(posedge clk); #2; n++; end while (acc_cnt == prev && n < 60);
      if (acc_cnt == prev) check("rand_accept_timeout", 0, 1);
    end
    tx_valid = 0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("rand_recovered", rec_cnt - rec0, 1000);
    check("rand_pending", sent_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
